// File: rtl/romload_streamer.sv
// romload_streamer
//   Streams a ROM image written by firmware over MMIO into the console core.
//   The first HDR_WORDS data words after a start command are captured as header
//   words; the remaining words are buffered in a DEPTH-word FIFO and serialised
//   little-endian into OUT_W-bit beats under ready/valid flow control.
//
// Ports
//   wclk, resetn          clock, synchronous active-low reset
//   ctrl_we, ctrl_di      control write: 1 = start load, 0 = finish load
//   data_we, data_di      32-bit data word write
//   data_wait             CPU must hold the data write (payload FIFO full)
//   status_do             {20'b0, level[7:0], full, empty, state[1:0]}
//   hdr_flat              captured header words, word i at [32i+31:32i]
//   rom_loading           high from start until the payload has fully drained
//   rom_do, rom_do_valid  output beat and its valid flag
//   rom_do_ready          sink accepts the beat when valid && ready
//   rom_bytes             payload bytes accepted by the sink since start (saturating)
module romload_streamer #(
    parameter int DEPTH     = 4,
    parameter int OUT_W     = 8,
    parameter int HDR_WORDS = 3
) (
    input  logic                      wclk,
    input  logic                      resetn,
    input  logic                      ctrl_we,
    input  logic [7:0]                ctrl_di,
    input  logic                      data_we,
    input  logic [31:0]               data_di,
    output logic                      data_wait,
    output logic [31:0]               status_do,
    output logic [32*HDR_WORDS-1:0]   hdr_flat,
    output logic                      rom_loading,
    output logic [OUT_W-1:0]          rom_do,
    output logic                      rom_do_valid,
    input  logic                      rom_do_ready,
    output logic [24:0]               rom_bytes
);

    localparam int          AW             = $clog2(DEPTH);
    localparam int          IW             = $clog2(HDR_WORDS + 1);
    localparam int          BEATS          = 32 / OUT_W;
    localparam logic [24:0] BYTES_PER_BEAT = 25'(OUT_W / 8);
    localparam logic [24:0] BYTES_MAX      = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t        state;
    logic [31:0]   mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic [AW:0]   level;
    logic          full;
    logic          empty;
    logic [31:0]   head;
    logic [31:0]   shreg;        // beats still to be presented after the current one
    logic [2:0]    beats_left;   // beats of the current word not yet accepted
    logic [IW-1:0] hdr_idx;
    logic          start;
    logic          finish;
    logic          push;
    logic          pop;
    logic          take;

    assign start  = ctrl_we && (ctrl_di == 8'd1);
    assign finish = ctrl_we && (ctrl_di == 8'd0);

    assign level = wptr - rptr;
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];

    assign data_wait = data_we && (state == DATA) && full;
    // A control write in the same cycle always wins and drops the data word.
    assign push      = data_we && !ctrl_we && (state == DATA) && !full;
    assign take      = rom_do_valid && rom_do_ready;
    // Refill when the serializer is empty, or back-to-back as its last beat leaves.
    assign pop       = !empty && ((beats_left == 3'd0) || (take && beats_left == 3'd1));

    assign status_do = {20'b0, 8'(level), full, empty, state};

    always_ff @(posedge wclk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= data_di;
        end
    end

    always_ff @(posedge wclk) begin
        if (!resetn) begin
            state        <= IDLE;
            wptr         <= '0;
            rptr         <= '0;
            shreg        <= '0;
            beats_left   <= '0;
            rom_do_valid <= 1'b0;
            rom_do       <= '0;
            hdr_flat     <= '0;
            hdr_idx      <= '0;
            rom_bytes    <= '0;
            rom_loading  <= 1'b0;
        end else if (start) begin
            state        <= HEADER;
            wptr         <= '0;
            rptr         <= '0;
            beats_left   <= '0;
            rom_do_valid <= 1'b0;
            rom_bytes    <= '0;
            hdr_idx      <= '0;
            rom_loading  <= 1'b1;
        end else begin
            case (state)
                HEADER: begin
                    if (finish) begin
                        state <= DRAIN;
                    end else if (data_we && !ctrl_we) begin
                        hdr_flat[32*hdr_idx +: 32] <= data_di;
                        hdr_idx <= hdr_idx + 1'b1;
                        if (hdr_idx == IW'(HDR_WORDS - 1)) begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (finish) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (empty && beats_left == 3'd0) begin
                        state       <= IDLE;
                        rom_loading <= 1'b0;
                    end
                end
                default: ;
            endcase

            if (push) begin
                wptr <= wptr + 1'b1;
            end

            if (pop) begin
                rptr         <= rptr + 1'b1;
                rom_do       <= head[OUT_W-1:0];
                shreg        <= head >> OUT_W;
                beats_left   <= 3'(BEATS);
                rom_do_valid <= 1'b1;
            end else if (take) begin
                if (beats_left == 3'd1) begin
                    beats_left   <= '0;
                    rom_do_valid <= 1'b0;
                end else begin
                    rom_do     <= shreg[OUT_W-1:0];
                    shreg      <= shreg >> OUT_W;
                    beats_left <= beats_left - 1'b1;
                end
            end

            if (take) begin
                if (rom_bytes > BYTES_MAX - BYTES_PER_BEAT) begin
                    rom_bytes <= BYTES_MAX;
                end else begin
                    rom_bytes <= rom_bytes + BYTES_PER_BEAT;
                end
            end
        end
    end

endmodule

// File: tb/tb_romload_streamer.sv
// tb_romload_streamer
//   Drives firmware-style load sequences into two streamer instances (8-bit and
//   16-bit beats) and compares the output byte stream with a byte queue built
//   from the words written, plus header, status and counter values.
module tb_romload_streamer;

    logic        wclk = 1'b0;
    always #5 wclk = ~wclk;

    // 8-bit beat instance
    logic        resetn;
    logic        ctrl_we;
    logic [7:0]  ctrl_di;
    logic        data_we;
    logic [31:0] data_di;
    logic        data_wait;
    logic [31:0] status_do;
    logic [95:0] hdr_flat;
    logic        rom_loading;
    logic [7:0]  rom_do;
    logic        rom_do_valid;
    logic        rom_do_ready;
    logic [24:0] rom_bytes;

    // 16-bit beat instance
    logic        c16_we;
    logic [7:0]  c16_di;
    logic        d16_we;
    logic [31:0] d16_di;
    logic        w16;
    logic [31:0] s16;
    logic [95:0] h16;
    logic        l16;
    logic [15:0] r16;
    logic        v16;
    logic        rdy16;
    logic [24:0] b16;

    romload_streamer #(.DEPTH(4), .OUT_W(8), .HDR_WORDS(3)) dut (
        .wclk(wclk), .resetn(resetn), .ctrl_we(ctrl_we), .ctrl_di(ctrl_di),
        .data_we(data_we), .data_di(data_di), .data_wait(data_wait),
        .status_do(status_do), .hdr_flat(hdr_flat), .rom_loading(rom_loading),
        .rom_do(rom_do), .rom_do_valid(rom_do_valid), .rom_do_ready(rom_do_ready),
        .rom_bytes(rom_bytes)
    );

    romload_streamer #(.DEPTH(4), .OUT_W(16), .HDR_WORDS(3)) dut16 (
        .wclk(wclk), .resetn(resetn), .ctrl_we(c16_we), .ctrl_di(c16_di),
        .data_we(d16_we), .data_di(d16_di), .data_wait(w16),
        .status_do(s16), .hdr_flat(h16), .rom_loading(l16),
        .rom_do(r16), .rom_do_valid(v16), .rom_do_ready(rdy16),
        .rom_bytes(b16)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ready source: 0 = low, 1 = high, 2 = pseudo-random per cycle
    int   ready_mode = 0;
    logic rand_ready = 1'b0;
    assign rom_do_ready = (ready_mode == 2) ? rand_ready : (ready_mode == 1);

    initial begin
        forever begin
            @(posedge wclk);
            #1;
            rand_ready = 1'($urandom_range(0, 1));
        end
    end

    // reference model: header words and the expected payload byte stream
    logic [31:0] m_hdr [3];
    int          m_hdr_cnt = 0;
    logic [7:0]  exp_q [$];

    // monitor state
    int          neg_cnt = 0;
    int          fall_neg = -1;
    int          beat_neg [$];
    logic        prev_loading = 1'b0;
    logic        stall_prev = 1'b0;
    logic [7:0]  stall_do = '0;
    logic [7:0]  mon_exp;

    always @(negedge wclk) begin
        if (!resetn || (ctrl_we && ctrl_di == 8'd1)) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                n_checks++;
                if (rom_do_valid !== 1'b1 || rom_do !== stall_do) begin
                    n_fail++;
                    $display("FAIL stall_hold: valid=%b do=%h, required valid=1 do=%h",
                             rom_do_valid, rom_do, stall_do);
                end
            end
            if (rom_do_valid === 1'b1 && rom_do_ready === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat_order: got beat %h, required no beat", rom_do);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (rom_do !== mon_exp) begin
                        n_fail++;
                        $display("FAIL beat_order: got %h, required %h", rom_do, mon_exp);
                    end
                end
                beat_neg.push_back(neg_cnt);
            end
            stall_prev = rom_do_valid && !rom_do_ready;
            stall_do   = rom_do;
        end
        if (prev_loading === 1'b1 && rom_loading === 1'b0) begin
            fall_neg = neg_cnt;
        end
        prev_loading = rom_loading;
        neg_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc;
        @(posedge wclk);
        #1;
    endtask

    task automatic ctrl_write(input logic [7:0] v);
        ctrl_we = 1'b1;
        ctrl_di = v;
        cyc();
        ctrl_we = 1'b0;
        if (v == 8'd1) begin
            exp_q.delete();
            m_hdr_cnt = 0;
        end
    endtask

    // Offers a word, holding it while data_wait is high (bounded), and updates the model.
    task automatic load_word(input logic [31:0] w, input int max_wait, output bit ok);
        int   waited;
        logic waiting;
        ok      = 1'b1;
        waited  = 0;
        data_we = 1'b1;
        data_di = w;
        do begin
            @(negedge wclk);
            waiting = data_wait;
            if (waiting) begin
                if (waited >= max_wait) begin
                    ok      = 1'b0;
                    waiting = 1'b0;
                end else begin
                    waited++;
                    @(posedge wclk);
                end
            end
        end while (waiting);
        @(posedge wclk);
        #1;
        data_we = 1'b0;
        if (m_hdr_cnt < 3) begin
            m_hdr[m_hdr_cnt] = w;
            m_hdr_cnt++;
        end else begin
            for (int unsigned b = 0; b < 4; b++) begin
                exp_q.push_back(8'(w >> (8 * b)));
            end
        end
    endtask

    task automatic wait_loading_low(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge wclk);
            if (rom_loading === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge wclk);
        #1;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (2) cyc();
        resetn = 1'b1;
        n_checks++;
        if (status_do !== 32'h4 || rom_loading !== 1'b0 || rom_do_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: status=%h loading=%b valid=%b, required 00000004/0/0",
                     status_do, rom_loading, rom_do_valid);
        end
        n_checks++;
        if (rom_do !== 8'h0 || hdr_flat !== 96'h0 || rom_bytes !== 25'h0) begin
            n_fail++;
            $display("FAIL reset_data: do=%h hdr=%h bytes=%0d, required zeros", rom_do, hdr_flat, rom_bytes);
        end
        n_checks++;
        if (s16 !== 32'h4 || l16 !== 1'b0 || v16 !== 1'b0 || r16 !== 16'h0 || b16 !== 25'h0) begin
            n_fail++;
            $display("FAIL reset_w16: status=%h loading=%b valid=%b do=%h bytes=%0d, required reset values",
                     s16, l16, v16, r16, b16);
        end
    endtask

    task automatic test_basic;
        bit ok;
        bit ok_all;
        int b0;
        int last;
        ok_all     = 1'b1;
        ready_mode = 1;
        ctrl_write(8'd1);
        load_word(32'h11, 0, ok); ok_all &= ok;
        load_word(32'h22, 0, ok); ok_all &= ok;
        load_word(32'h33, 0, ok); ok_all &= ok;
        b0 = beat_neg.size();
        load_word(32'h44332211, 0, ok); ok_all &= ok;
        ctrl_write(8'd0);
        wait_loading_low(50, ok);
        n_checks++;
        if (!(ok_all && ok)) begin
            n_fail++;
            $display("FAIL t1_flow: writes_ok=%b drained=%b, required 1/1", ok_all, ok);
        end
        n_checks++;
        if (hdr_flat !== {32'h33, 32'h22, 32'h11}) begin
            n_fail++;
            $display("FAIL t1_hdr: got %h, required %h", hdr_flat, {32'h33, 32'h22, 32'h11});
        end
        n_checks++;
        if (beat_neg.size() - b0 != 4) begin
            n_fail++;
            $display("FAIL t1_beats: got %0d beats, required 4", beat_neg.size() - b0);
        end else begin
            last = beat_neg[b0 + 3];
            n_checks++;
            if (last - beat_neg[b0] != 3) begin
                n_fail++;
                $display("FAIL t1_consecutive: beats span %0d cycles, required 3", last - beat_neg[b0]);
            end
            n_checks++;
            if (fall_neg - last != 2) begin
                n_fail++;
                $display("FAIL t1_loading_fall: fell %0d samples after last beat, required 2", fall_neg - last);
            end
        end
        n_checks++;
        if (rom_bytes !== 25'd4) begin
            n_fail++;
            $display("FAIL t1_bytes: got %0d, required 4", rom_bytes);
        end
    endtask

    task automatic test_wide;
        rdy16  = 1'b0;
        c16_we = 1'b1; c16_di = 8'd1; cyc(); c16_we = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            d16_we = 1'b1; d16_di = $urandom; cyc(); d16_we = 1'b0;
        end
        d16_we = 1'b1; d16_di = 32'hDEADBEEF; cyc(); d16_we = 1'b0;
        c16_we = 1'b1; c16_di = 8'd0; cyc(); c16_we = 1'b0;
        n_checks++;
        if (v16 !== 1'b1 || r16 !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL t2_beat0: valid=%b do=%h, required 1/beef", v16, r16);
        end
        rdy16 = 1'b1;
        cyc();
        n_checks++;
        if (v16 !== 1'b1 || r16 !== 16'hDEAD || b16 !== 25'd2) begin
            n_fail++;
            $display("FAIL t2_beat1: valid=%b do=%h bytes=%0d, required 1/dead/2", v16, r16, b16);
        end
        cyc();
        n_checks++;
        if (v16 !== 1'b0 || b16 !== 25'd4) begin
            n_fail++;
            $display("FAIL t2_done: valid=%b bytes=%0d, required 0/4", v16, b16);
        end
        cyc();
        n_checks++;
        if (l16 !== 1'b0 || s16[1:0] !== 2'd0) begin
            n_fail++;
            $display("FAIL t2_idle: loading=%b state=%0d, required 0/0", l16, s16[1:0]);
        end
        rdy16 = 1'b0;
    endtask

    task automatic test_backpressure;
        bit          ok;
        bit          ok_all;
        int          b0;
        logic [31:0] w6;
        ok_all     = 1'b1;
        ready_mode = 0;
        ctrl_write(8'd1);
        for (int unsigned i = 0; i < 3; i++) begin
            load_word($urandom, 0, ok); ok_all &= ok;
        end
        b0 = beat_neg.size();
        for (int unsigned i = 0; i < 5; i++) begin
            load_word($urandom, 0, ok); ok_all &= ok;
        end
        w6      = $urandom;
        data_we = 1'b1;
        data_di = w6;
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge wclk);
            n_checks++;
            if (data_wait !== 1'b1) begin
                n_fail++;
                $display("FAIL t3_wait: data_wait=%b, required 1", data_wait);
            end
        end
        n_checks++;
        if (status_do[11:4] !== 8'd4 || status_do[3] !== 1'b1 || status_do[1:0] !== 2'd2) begin
            n_fail++;
            $display("FAIL t3_status: level=%0d full=%b state=%0d, required 4/1/2",
                     status_do[11:4], status_do[3], status_do[1:0]);
        end
        @(posedge wclk);
        #1;
        ready_mode = 1;
        load_word(w6, 20, ok); ok_all &= ok;
        ctrl_write(8'd0);
        wait_loading_low(200, ok);
        n_checks++;
        if (!(ok_all && ok) || exp_q.size() != 0 || beat_neg.size() - b0 != 24 || rom_bytes !== 25'd24) begin
            n_fail++;
            $display("FAIL t3_stream: ok=%b/%b left=%0d beats=%0d bytes=%0d, required 1/1/0/24/24",
                     ok_all, ok, exp_q.size(), beat_neg.size() - b0, rom_bytes);
        end
    endtask

    task automatic test_random_ready;
        bit ok;
        bit ok_all;
        int b0;
        ok_all     = 1'b1;
        ready_mode = 2;
        ctrl_write(8'd1);
        b0 = beat_neg.size();
        for (int unsigned i = 0; i < 67; i++) begin
            load_word($urandom, 50, ok); ok_all &= ok;
        end
        // finish together with a data write: the word must be dropped
        ctrl_we = 1'b1; ctrl_di = 8'd0; data_we = 1'b1; data_di = $urandom;
        cyc();
        ctrl_we = 1'b0; data_we = 1'b0;
        wait_loading_low(2000, ok);
        n_checks++;
        if (!(ok_all && ok) || exp_q.size() != 0 || beat_neg.size() - b0 != 256) begin
            n_fail++;
            $display("FAIL t4_stream: ok=%b/%b left=%0d beats=%0d, required 1/1/0/256",
                     ok_all, ok, exp_q.size(), beat_neg.size() - b0);
        end
        n_checks++;
        if (rom_bytes !== 25'd256) begin
            n_fail++;
            $display("FAIL t4_bytes: got %0d, required 256", rom_bytes);
        end
        n_checks++;
        if (hdr_flat !== {m_hdr[2], m_hdr[1], m_hdr[0]}) begin
            n_fail++;
            $display("FAIL t4_hdr: got %h, required %h", hdr_flat, {m_hdr[2], m_hdr[1], m_hdr[0]});
        end
        ready_mode = 0;
    endtask

    task automatic test_restart;
        bit ok;
        bit ok_all;
        int b0;
        ok_all     = 1'b1;
        ready_mode = 0;
        ctrl_write(8'd1);
        b0 = beat_neg.size();
        for (int unsigned i = 0; i < 6; i++) begin
            load_word($urandom, 0, ok); ok_all &= ok;
        end
        ready_mode = 1;
        cyc();
        cyc();
        ready_mode = 0;
        cyc();
        n_checks++;
        if (!ok_all || rom_do_valid !== 1'b1 || rom_bytes !== 25'(beat_neg.size() - b0)) begin
            n_fail++;
            $display("FAIL t5_pending: ok=%b valid=%b bytes=%0d, required 1/1/%0d",
                     ok_all, rom_do_valid, rom_bytes, beat_neg.size() - b0);
        end
        ctrl_write(8'd1);
        n_checks++;
        if (rom_do_valid !== 1'b0 || rom_bytes !== 25'd0 || status_do !== 32'h5) begin
            n_fail++;
            $display("FAIL t5_flush: valid=%b bytes=%0d status=%h, required 0/0/00000005",
                     rom_do_valid, rom_bytes, status_do);
        end
        ctrl_write(8'd0);
        n_checks++;
        if (status_do[1:0] !== 2'd3 || rom_loading !== 1'b1) begin
            n_fail++;
            $display("FAIL t5_drain: state=%0d loading=%b, required 3/1", status_do[1:0], rom_loading);
        end
        cyc();
        n_checks++;
        if (status_do[1:0] !== 2'd0 || rom_loading !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_idle: state=%0d loading=%b, required 0/0", status_do[1:0], rom_loading);
        end
        b0         = beat_neg.size();
        ready_mode = 1;
        repeat (6) cyc();
        n_checks++;
        if (beat_neg.size() != b0) begin
            n_fail++;
            $display("FAIL t5_no_beats: got %0d beats, required 0", beat_neg.size() - b0);
        end
        ready_mode = 0;
    endtask

    task automatic test_reset_in_drain;
        bit ok;
        bit ok_all;
        int b0;
        ok_all     = 1'b1;
        ready_mode = 0;
        ctrl_write(8'd1);
        for (int unsigned i = 0; i < 5; i++) begin
            load_word($urandom, 0, ok); ok_all &= ok;
        end
        ctrl_write(8'd0);
        n_checks++;
        if (!ok_all || status_do[1:0] !== 2'd3 || rom_do_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL t6_pre: ok=%b state=%0d valid=%b, required 1/3/1", ok_all, status_do[1:0], rom_do_valid);
        end
        resetn = 1'b0;
        cyc();
        resetn = 1'b1;
        exp_q.delete();
        m_hdr_cnt = 0;
        n_checks++;
        if (status_do !== 32'h4 || rom_loading !== 1'b0 || rom_do_valid !== 1'b0 ||
            rom_do !== 8'h0 || hdr_flat !== 96'h0 || rom_bytes !== 25'h0) begin
            n_fail++;
            $display("FAIL t6_reset: status=%h loading=%b valid=%b do=%h hdr=%h bytes=%0d, required reset values",
                     status_do, rom_loading, rom_do_valid, rom_do, hdr_flat, rom_bytes);
        end
        b0         = beat_neg.size();
        ready_mode = 1;
        data_we    = 1'b1;
        data_di    = $urandom;
        @(negedge wclk);
        n_checks++;
        if (data_wait !== 1'b0) begin
            n_fail++;
            $display("FAIL t6_idle_wait: data_wait=%b, required 0", data_wait);
        end
        @(posedge wclk);
        #1;
        data_we = 1'b0;
        repeat (6) cyc();
        n_checks++;
        if (beat_neg.size() != b0 || status_do !== 32'h4) begin
            n_fail++;
            $display("FAIL t6_quiet: beats=%0d status=%h, required 0/00000004", beat_neg.size() - b0, status_do);
        end
        ready_mode = 0;
    endtask

    initial begin
        resetn  = 1'b0;
        ctrl_we = 1'b0; ctrl_di = '0; data_we = 1'b0; data_di = '0;
        c16_we  = 1'b0; c16_di  = '0; d16_we  = 1'b0; d16_di  = '0; rdy16 = 1'b0;
        test_reset();
        test_basic();
        test_wide();
        test_backpressure();
        test_random_ready();
        test_restart();
        test_reset_in_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
